// File: rtl/char_num_scanner.sv
// Character-stream number scanner: turns runs of decimal/hex digit characters
// into saturating unsigned tokens delivered over a valid/ready output port.
module char_num_scanner #(
  parameter int VAL_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hex_mode,
  output logic [VAL_W-1:0] out,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] tok_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_NUM  = 1'b1;
  localparam int         EXT_W  = VAL_W + 5;

  logic [0:0]       state_q, state_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             hex_q, hex_d;
  logic [VAL_W-1:0] out_q, out_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] tok_cnt_q, tok_cnt_d;

  logic             radix_hex, is_dig, accept, emit, mac_ovf;
  logic [3:0]       dig_val;
  logic [EXT_W-1:0] acc_ext, mac;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  // Radix comes from the live pin only on a token's first digit.
  assign radix_hex = (state_q == S_NUM) ? hex_q : hex_mode;

  always_comb begin
    is_dig  = 1'b0;
    dig_val = 4'd0;
    if (in >= 8'h30 && in <= 8'h39) begin
      is_dig  = 1'b1;
      dig_val = in[3:0];
    end else if (radix_hex && ((in >= 8'h61 && in <= 8'h66) ||
                               (in >= 8'h41 && in <= 8'h46))) begin
      is_dig  = 1'b1;
      dig_val = in[3:0] + 4'd9;
    end
  end

  // Five spare bits hold acc*16+15 without wrapping, so overflow is exact.
  always_comb begin
    acc_ext = {5'b0, acc_q};
    mac     = hex_q ? (acc_ext << 4) : ((acc_ext << 3) + (acc_ext << 1));
    mac     = mac + EXT_W'(dig_val);
    mac_ovf = |mac[EXT_W-1:VAL_W];
  end

  assign emit = accept && (state_q == S_NUM) && !is_dig;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    if (accept && is_dig) begin
      if (state_q == S_IDLE) begin
        state_d = S_NUM;
        acc_d   = VAL_W'(dig_val);
        ovf_d   = 1'b0;
        hex_d   = hex_mode;
      end else if (mac_ovf) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = mac[VAL_W-1:0];
      end
    end else if (emit) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    tok_cnt_d   = tok_cnt_q;
    if (emit) begin
      out_d       = acc_q;
      out_ovf_d   = ovf_q;
      out_valid_d = 1'b1;
      tok_cnt_d   = tok_cnt_q + CNT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      hex_q       <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      tok_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      hex_q       <= hex_d;
      out_q       <= out_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      tok_cnt_q   <= tok_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;
  assign tok_cnt   = tok_cnt_q;

endmodule
